// File: rtl/axi4_master_read_burst.sv
// AXI4 read master: fetches one INCR burst of BURST_LEN beats
// and assembles it into a single line with fault/protocol flags.
module axi4_master_read_burst #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BURST_LEN      = 16,
  localparam int LINE_WIDTH    = BURST_LEN * AXI_DATA_WIDTH,
  localparam int SIZE          = $clog2(AXI_DATA_WIDTH / 8)
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
  input  logic                      i_start_read,
  output logic [LINE_WIDTH-1:0]     o_data,
  output logic                      o_access_fault,
  output logic                      o_protocol_error,
  output logic                      o_done,
  output logic                      o_busy,
  input  logic                      AR_READY,
  output logic                      AR_VALID,
  output logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
  output logic [7:0]                AR_LEN,
  output logic [2:0]                AR_SIZE,
  output logic [1:0]                AR_BURST,
  output logic [2:0]                AR_PROT,
  input  logic [AXI_DATA_WIDTH-1:0] R_DATA,
  input  logic [1:0]                R_RESP,
  input  logic                      R_LAST,
  input  logic                      R_VALID,
  output logic                      R_READY
);

  localparam int CW = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]       data_q, data_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        fault_q, fault_d;
  logic                        perr_q, perr_d;
  logic                        last_idx;
  logic                        in_range;

  assign last_idx = (cnt_q == CW'(BURST_LEN - 1));
  assign in_range = (cnt_q < CW'(BURST_LEN));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    perr_d  = perr_q;
    unique case (state_q)
      IDLE: begin
        if (i_start_read) begin
          addr_d  = {i_addr[AXI_ADDR_WIDTH-1:SIZE], SIZE'(0)};
          data_d  = '0;
          cnt_d   = '0;
          fault_d = 1'b0;
          perr_d  = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (AR_READY) state_d = DATA;
      end
      DATA: begin
        if (R_VALID) begin
          // Overflow beats are dropped; the counter saturates.
          if (in_range) begin
            for (int k = 0; k < BURST_LEN; k++) begin
              if (cnt_q == CW'(k)) begin
                data_d[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = R_DATA;
              end
            end
            cnt_d = cnt_q + CW'(1);
          end else begin
            perr_d = 1'b1;
          end
          fault_d = fault_q | R_RESP[1];
          if (R_LAST != last_idx) perr_d = 1'b1;
          if (R_LAST) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign AR_VALID         = (state_q == ADDR);
  assign R_READY          = (state_q == DATA);
  assign o_done           = (state_q == DONE);
  assign o_busy           = (state_q != IDLE);
  assign AR_ADDR          = addr_q;
  assign o_data           = data_q;
  assign o_access_fault   = fault_q;
  assign o_protocol_error = perr_q;
  assign AR_LEN           = 8'(BURST_LEN - 1);
  assign AR_SIZE          = 3'(SIZE);
  assign AR_BURST         = 2'b01;
  assign AR_PROT          = 3'b100;

  logic unused_ok;
  assign unused_ok = ^{R_RESP[0], i_addr[SIZE-1:0]};

endmodule

// File: tb/tb_axi4_master_read_burst.sv
// Directed bench for axi4_master_read_burst with an R-channel
// responder and a line scoreboard checked on every o_done.
module tb_axi4_master_read_burst;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam int LW = BL * DW;

  logic          clk = 1'b0;
  logic          arst;
  logic [AW-1:0] i_addr;
  logic          i_start_read;
  logic [LW-1:0] o_data;
  logic          o_access_fault;
  logic          o_protocol_error;
  logic          o_done;
  logic          o_busy;
  logic          AR_READY;
  logic          AR_VALID;
  logic [AW-1:0] AR_ADDR;
  logic [7:0]    AR_LEN;
  logic [2:0]    AR_SIZE;
  logic [1:0]    AR_BURST;
  logic [2:0]    AR_PROT;
  logic [DW-1:0] R_DATA;
  logic [1:0]    R_RESP;
  logic          R_LAST;
  logic          R_VALID;
  logic          R_READY;

  always #5 clk = ~clk;

  axi4_master_read_burst #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .BURST_LEN     (BL)
  ) dut (
    .clk             (clk),
    .arst            (arst),
    .i_addr          (i_addr),
    .i_start_read    (i_start_read),
    .o_data          (o_data),
    .o_access_fault  (o_access_fault),
    .o_protocol_error(o_protocol_error),
    .o_done          (o_done),
    .o_busy          (o_busy),
    .AR_READY        (AR_READY),
    .AR_VALID        (AR_VALID),
    .AR_ADDR         (AR_ADDR),
    .AR_LEN          (AR_LEN),
    .AR_SIZE         (AR_SIZE),
    .AR_BURST        (AR_BURST),
    .AR_PROT         (AR_PROT),
    .R_DATA          (R_DATA),
    .R_RESP          (R_RESP),
    .R_LAST          (R_LAST),
    .R_VALID         (R_VALID),
    .R_READY         (R_READY)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic          l;
  } beat_t;

  typedef struct {
    logic [LW-1:0] line;
    logic          f;
    logic          p;
  } exp_t;

  beat_t rq[$];
  exp_t  sb[$];
  int    checks    = 0;
  int    failures  = 0;
  int    done_seen = 0;
  int    accepted  = 0;
  int    gap_pct   = 0;
  bit    hs;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Reference line model built from the beats the responder will send.
  task automatic queue_burst(input logic [DW-1:0] base, input int n,
                             input int bad, output exp_t e);
    beat_t b;
    e.line = '0;
    e.f    = 1'b0;
    e.p    = 1'b0;
    for (int k = 0; k < n; k++) begin
      b.d = base + DW'(k);
      b.r = (k == bad) ? 2'b10 : 2'b00;
      b.l = (k == n - 1);
      rq.push_back(b);
      if (k < BL) e.line[k*DW +: DW] = b.d;
      else e.p = 1'b1;
      e.f = e.f | b.r[1];
      if (b.l != (k == BL - 1)) e.p = 1'b1;
    end
  endtask

  task automatic start(input logic [AW-1:0] a, input exp_t e);
    sb.push_back(e);
    accepted++;
    i_addr       = a;
    i_start_read = 1'b1;
    step();
    i_start_read = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (sb.size() == 0 && !o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 128'(ok), 128'(1));
  endtask

  initial begin
    R_VALID = 1'b0;
    R_DATA  = '0;
    R_RESP  = '0;
    R_LAST  = 1'b0;
    hs      = 1'b0;
    forever begin
      @(negedge clk);
      if (arst) begin
        R_VALID = 1'b0;
        hs      = 1'b0;
      end else begin
        if (hs) void'(rq.pop_front());
        if (rq.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
          R_VALID = 1'b1;
          R_DATA  = rq[0].d;
          R_RESP  = rq[0].r;
          R_LAST  = rq[0].l;
        end else begin
          R_VALID = 1'b0;
        end
        hs = R_VALID && R_READY;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_done) begin
        done_seen++;
        chk("done_expected", 128'(sb.size() > 0), 128'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("line", o_data, e.line);
          chk("access_fault", 128'(o_access_fault), 128'(e.f));
          chk("protocol_error", 128'(o_protocol_error), 128'(e.p));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   cyc;
    bit   found;
    arst         = 1'b1;
    i_addr       = '0;
    i_start_read = 1'b0;
    AR_READY     = 1'b0;
    step();
    step();
    chk("rst_ar_valid", 128'(AR_VALID), 128'(0));
    chk("rst_r_ready", 128'(R_READY), 128'(0));
    chk("rst_ar_addr", 128'(AR_ADDR), 128'(0));
    chk("rst_data", o_data, 128'(0));
    chk("rst_done", 128'(o_done), 128'(0));
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_fault", 128'(o_access_fault), 128'(0));
    chk("rst_perr", 128'(o_protocol_error), 128'(0));
    chk("ar_len", 128'(AR_LEN), 128'(3));
    chk("ar_size", 128'(AR_SIZE), 128'(2));
    chk("ar_burst", 128'(AR_BURST), 128'(1));
    chk("ar_prot", 128'(AR_PROT), 128'(4));
    arst = 1'b0;
    step();

    // Minimum-latency burst; start cycle is cycle 1.
    AR_READY = 1'b1;
    queue_burst(32'hA0, 4, -1, e);
    sb.push_back(e);
    accepted++;
    i_addr       = 64'h1003;
    i_start_read = 1'b1;
    cyc          = 1;
    found        = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      i_start_read = 1'b0;
      cyc++;
      if (cyc == 2) begin
        chk("lat_ar_valid", 128'(AR_VALID), 128'(1));
        chk("lat_ar_addr", 128'(AR_ADDR), 128'h1000);
      end
      if (o_done) found = 1'b1;
    end
    chk("done_cycle", 128'(cyc), 128'(BL + 3));
    wait_idle("idle_lat");

    // AR_READY stalled for 5 cycles.
    AR_READY = 1'b0;
    queue_burst(32'hB0, 4, -1, e);
    start(64'h2007, e);
    for (int i = 0; i < 5; i++) begin
      chk("stall_ar_valid", 128'(AR_VALID), 128'(1));
      chk("stall_ar_addr", 128'(AR_ADDR), 128'h2004);
      chk("stall_r_ready", 128'(R_READY), 128'(0));
      step();
    end
    AR_READY = 1'b1;
    step();
    chk("hs_ar_valid", 128'(AR_VALID), 128'(0));
    chk("hs_r_ready", 128'(R_READY), 128'(1));
    wait_idle("idle_stall");

    queue_burst(32'hC0, 4, 2, e);
    start(64'h3000, e);
    wait_idle("idle_fault");

    queue_burst(32'hD0, 2, -1, e);
    start(64'h4000, e);
    wait_idle("idle_early_last");

    queue_burst(32'hE0, 5, -1, e);
    start(64'h5000, e);
    wait_idle("idle_overrun");

    // Reset after two beats of a burst.
    queue_burst(32'hF0, 4, -1, e);
    start(64'h6000, e);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (rq.size() == 2) found = 1'b1;
    end
    chk("two_beats_taken", 128'(found), 128'(1));
    chk("pre_rst_busy", 128'(o_busy), 128'(1));
    arst = 1'b1;
    #1;
    chk("mid_rst_ar_valid", 128'(AR_VALID), 128'(0));
    chk("mid_rst_r_ready", 128'(R_READY), 128'(0));
    chk("mid_rst_busy", 128'(o_busy), 128'(0));
    chk("mid_rst_data", o_data, 128'(0));
    chk("mid_rst_addr", 128'(AR_ADDR), 128'(0));
    sb.delete();
    rq.delete();
    accepted--;
    step();
    arst = 1'b0;
    step();
    queue_burst(32'h10, 4, -1, e);
    start(64'h7000, e);
    wait_idle("idle_post_rst");

    // Random R_VALID gaps plus an ignored start while busy.
    gap_pct = 40;
    for (int n = 0; n < 3; n++) begin
      queue_burst(32'h100 * (n + 1), 4, (n == 1) ? 0 : -1, e);
      start(64'h8000 + 64'(n * 64), e);
      step();
      step();
      chk("poke_busy", 128'(o_busy), 128'(1));
      i_addr       = 64'hDEAD00;
      i_start_read = 1'b1;
      step();
      i_start_read = 1'b0;
      chk("poke_addr", 128'(AR_ADDR), 128'(64'h8000 + 64'(n * 64)));
      wait_idle("idle_gap");
    end
    for (int i = 0; i < 4; i++) step();
    chk("no_queued_start", 128'(o_busy), 128'(0));
    chk("done_count", 128'(done_seen), 128'(accepted));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
